// File: rtl/flush_ctrl.sv
// Pipeline flush / fetch redirect controller. Accepts taken-branch, jump and
// exception events from EX while idle, holds flush_o and keeps the redirect up
// until fetch takes it.
module flush_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid_i,
   input  logic              ex_branch_i,
   input  logic              ex_taken_i,
   input  logic              ex_jump_i,
   input  logic [31:0]       ex_target_i,
   input  logic              exc_valid_i,
   input  logic [31:0]       trap_vec_i,
   input  logic              fetch_ready_i,
   output logic              flush_o,
   output logic              redirect_valid_o,
   output logic [31:0]       redirect_pc_o,
   output logic              misalign_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  flush_count_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              flush_q;
   logic              rv_q;
   logic [31:0]       pc_q;
   logic              misalign_q;
   logic [CNT_W-1:0]  count_q;

   logic              exc_ev;
   logic              ctl_ev;
   logic              misalign_d;
   logic [31:0]       target_d;

   // Event decode; only consulted in IDLE, later events are wrong-path.
   always_comb begin
      exc_ev     = ex_valid_i & exc_valid_i;
      ctl_ev     = ex_valid_i & ((ex_branch_i & ex_taken_i) | ex_jump_i);
      misalign_d = ctl_ev & ~exc_ev & (ex_target_i[1:0] != 2'b00);
      target_d   = (exc_ev | misalign_d) ? trap_vec_i : ex_target_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         flush_q    <= 1'b0;
         rv_q       <= 1'b0;
         pc_q       <= 32'd0;
         misalign_q <= 1'b0;
         count_q    <= '0;
      end else begin
         misalign_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (exc_ev | ctl_ev) begin
                  state_q    <= FLUSH;
                  cnt_q      <= CNT_INIT;
                  flush_q    <= 1'b1;
                  rv_q       <= 1'b1;
                  pc_q       <= target_d;
                  misalign_q <= misalign_d;
                  if (count_q != '1) count_q <= count_q + 1'b1;
               end
            end
            FLUSH: begin
               // rv_q low here means fetch already took the redirect earlier.
               if (rv_q & fetch_ready_i) rv_q <= 1'b0;
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  flush_q <= 1'b0;
                  if (!rv_q || fetch_ready_i) state_q <= IDLE;
                  else                        state_q <= WAIT;
               end
            end
            WAIT: begin
               if (fetch_ready_i) begin
                  rv_q    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               flush_q <= 1'b0;
               rv_q    <= 1'b0;
            end
         endcase
      end
   end

   assign flush_o          = flush_q;
   assign redirect_valid_o = rv_q;
   assign redirect_pc_o    = pc_q;
   assign misalign_o       = misalign_q;
   assign busy_o           = (state_q != IDLE);
   assign flush_count_o    = count_q;

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed bench for flush_ctrl: u_a uses FLUSH_CYCLES=1/CNT_W=16, u_b uses
// FLUSH_CYCLES=2/CNT_W=2 so counter saturation is reachable in a few events.
module tb_flush_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_branch, ex_taken, ex_jump, exc_valid, fetch_ready;
   logic [31:0] ex_target, trap_vec;

   logic        a_flush, a_rv, a_mis, a_busy;
   logic [31:0] a_pc;
   logic [15:0] a_cnt;
   logic        b_flush, b_rv, b_mis, b_busy;
   logic [31:0] b_pc;
   logic [1:0]  b_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   flush_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .ex_branch_i(ex_branch),
      .ex_taken_i(ex_taken), .ex_jump_i(ex_jump), .ex_target_i(ex_target),
      .exc_valid_i(exc_valid), .trap_vec_i(trap_vec), .fetch_ready_i(fetch_ready),
      .flush_o(a_flush), .redirect_valid_o(a_rv), .redirect_pc_o(a_pc),
      .misalign_o(a_mis), .busy_o(a_busy), .flush_count_o(a_cnt));

   flush_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .ex_branch_i(ex_branch),
      .ex_taken_i(ex_taken), .ex_jump_i(ex_jump), .ex_target_i(ex_target),
      .exc_valid_i(exc_valid), .trap_vec_i(trap_vec), .fetch_ready_i(fetch_ready),
      .flush_o(b_flush), .redirect_valid_o(b_rv), .redirect_pc_o(b_pc),
      .misalign_o(b_mis), .busy_o(b_busy), .flush_count_o(b_cnt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_ex();
      ex_valid = 0; ex_branch = 0; ex_taken = 0; ex_jump = 0; exc_valid = 0;
      ex_target = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_ex();
      tick();
      rst = 1'b0;
   endtask

   // Outputs of u_a as {flush, rv, misalign, busy}
   function automatic logic [31:0] a_flags();
      return {28'd0, a_flush, a_rv, a_mis, a_busy};
   endfunction

   function automatic logic [31:0] b_flags();
      return {28'd0, b_flush, b_rv, b_mis, b_busy};
   endfunction

   initial begin
      rst = 1'b1; fetch_ready = 1'b0; trap_vec = 32'h8000_0000;
      clear_ex();

      // Reset and idle cycles, including non-valid EX garbage
      do_reset();
      chk("rst_a_flags", a_flags(), 32'h0);
      chk("rst_a_pc",    a_pc,      32'h0);
      chk("rst_a_cnt",   {16'd0, a_cnt}, 32'h0);
      chk("rst_b_flags", b_flags(), 32'h0);
      ex_jump = 1; exc_valid = 1; ex_target = 32'h0000_0040;
      for (int i = 0; i < 5; i++) tick();
      clear_ex();
      chk("idle_a_flags", a_flags(), 32'h0);
      chk("idle_a_cnt",   {16'd0, a_cnt}, 32'h0);
      chk("idle_b_cnt",   {30'd0, b_cnt}, 32'h0);

      // Taken branch, fetch always ready, FLUSH_CYCLES=1
      fetch_ready = 1;
      ex_valid = 1; ex_branch = 1; ex_taken = 1; ex_target = 32'h0000_0100;
      tick(); clear_ex();
      chk("br_t1_flags", a_flags(), 32'hD);
      chk("br_t1_pc",    a_pc,      32'h0000_0100);
      chk("br_t1_cnt",   {16'd0, a_cnt}, 32'd1);
      tick();
      chk("br_t2_flags", a_flags(), 32'h0);
      chk("br_t2_cnt",   {16'd0, a_cnt}, 32'd1);

      // Not-taken branch is no event
      ex_valid = 1; ex_branch = 1; ex_taken = 0; ex_target = 32'h0000_0500;
      tick(); clear_ex();
      chk("nt_flags", a_flags(), 32'h0);
      chk("nt_cnt",   {16'd0, a_cnt}, 32'd1);

      // Jump with fetch stalled 3 cycles, FLUSH_CYCLES=2 (u_b)
      do_reset();
      fetch_ready = 0;
      ex_valid = 1; ex_jump = 1; ex_target = 32'h0000_0200;
      tick(); clear_ex();
      chk("jw_t1_flags", b_flags(), 32'hD);
      chk("jw_t1_pc",    b_pc,      32'h0000_0200);
      ex_valid = 1; ex_branch = 1; ex_taken = 1; ex_target = 32'h0000_0400;
      tick(); clear_ex();
      chk("jw_t2_flags", b_flags(), 32'hD);
      tick();
      chk("jw_t3_flags", b_flags(), 32'h5);
      chk("jw_t3_pc",    b_pc,      32'h0000_0200);
      chk("jw_t3_cnt",   {30'd0, b_cnt}, 32'd1);
      tick();
      fetch_ready = 1;
      chk("jw_t4_flags", b_flags(), 32'h5);
      chk("jw_t4_pc",    b_pc,      32'h0000_0200);
      tick();
      chk("jw_t5_flags", b_flags(), 32'h0);
      chk("jw_t5_cnt",   {30'd0, b_cnt}, 32'd1);

      // Exception beats taken branch in the same cycle
      do_reset();
      fetch_ready = 1;
      ex_valid = 1; exc_valid = 1; ex_branch = 1; ex_taken = 1;
      ex_target = 32'h0000_0300;
      tick(); clear_ex();
      chk("exc_pc",    a_pc,      32'h8000_0000);
      chk("exc_flags", a_flags(), 32'hD);
      chk("exc_cnt",   {16'd0, a_cnt}, 32'd1);
      tick();

      // Misaligned jump redirects to the trap vector
      ex_valid = 1; ex_jump = 1; ex_target = 32'h0000_0102;
      tick(); clear_ex();
      chk("mis_flags", a_flags(), 32'hF);
      chk("mis_pc",    a_pc,      32'h8000_0000);
      chk("mis_cnt",   {16'd0, a_cnt}, 32'd2);
      tick();
      chk("mis_end_flags", a_flags(), 32'h0);

      // Reset while waiting for fetch
      do_reset();
      fetch_ready = 0;
      ex_valid = 1; ex_jump = 1; ex_target = 32'h0000_0200;
      tick(); clear_ex();
      tick(); tick();
      chk("rw_wait_flags", b_flags(), 32'h5);
      rst = 1;
      tick();
      rst = 0;
      chk("rw_rst_flags", b_flags(), 32'h0);
      chk("rw_rst_pc",    b_pc,      32'h0);
      chk("rw_rst_cnt",   {30'd0, b_cnt}, 32'd0);
      tick();
      chk("rw_after_flags", b_flags(), 32'h0);

      // Saturation of the 2-bit counter: 2 events preset, then 3 more
      do_reset();
      fetch_ready = 1;
      for (int i = 0; i < 5; i++) begin
         ex_valid = 1; ex_jump = 1; ex_target = 32'h0000_1000 + 32'(i * 4);
         tick(); clear_ex();
         chk($sformatf("sat_cnt_%0d", i), {30'd0, b_cnt}, (i >= 2) ? 32'd3 : 32'(i + 1));
         tick(); tick();
         chk($sformatf("sat_idle_%0d", i), b_flags(), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
